// File: rtl/maxnet_core_if.sv
// Host-side bundle for maxnet_core: start/ready handshake, parallel activation load and
// result reporting.
//   master: drives start, in_data (and eps_in when MAXNET_PROGEPS_EN is defined)
//   slave : drives ready, busy, done, winner_idx, winner_val, iter_count, timeout, tie
// MAXNET_PROGEPS_EN adds eps_in, a run-time epsilon latched at the accepted start.
interface maxnet_core_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ITER_W = 5,
  parameter int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1
);
  logic                  start;
  logic [N*DATA_W-1:0]   in_data;
`ifdef MAXNET_PROGEPS_EN
  logic [FRAC_W:0]       eps_in;
`endif
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [IDX_W-1:0]      winner_idx;
  logic [DATA_W-1:0]     winner_val;
  logic [ITER_W-1:0]     iter_count;
  logic                  timeout;
  logic                  tie;

  modport master (
    output start, in_data,
`ifdef MAXNET_PROGEPS_EN
    output eps_in,
`endif
    input  ready, busy, done, winner_idx, winner_val, iter_count, timeout, tie
  );

  modport slave (
    input  start, in_data,
`ifdef MAXNET_PROGEPS_EN
    input  eps_in,
`endif
    output ready, busy, done, winner_idx, winner_val, iter_count, timeout, tie
  );
endinterface

// File: rtl/maxnet_core.sv
// Parametrised Maxnet winner-take-all engine. Loads N unsigned activations on an accepted
// start, then alternates CHECK/UPDATE: each UPDATE subtracts eps * (sum of the other
// channels) from every channel at once, clamping at zero, until at most one channel is
// nonzero or MAX_ITER updates have been made. Results are registered on entry to DONE.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - maxnet_core_if slave (start/in_data in; ready/busy/done and results out)
// Optional: MAXNET_PROGEPS_EN takes epsilon from bus.eps_in (latched at start) instead
// of the EPS parameter.
module maxnet_core #(
  parameter int unsigned N        = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned EPS      = 32,
  parameter int unsigned MAX_ITER = 16,
  parameter int unsigned ITER_W   = 5
) (
  input logic         clk,
  input logic         rst,
  maxnet_core_if.slave bus
);
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SUM_W  = DATA_W + $clog2(N);
  localparam int unsigned PROD_W = SUM_W + FRAC_W + 1;
  localparam int unsigned CNT_W  = $clog2(N + 1);
  localparam logic [FRAC_W:0] EPS_C = (FRAC_W + 1)'(EPS);

  typedef enum logic [1:0] {StIdle, StCheck, StUpdate, StDone} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q [N];
  logic [DATA_W-1:0]   a_d [N];
  logic [N-1:0]        prevmask_q, prevmask_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [DATA_W-1:0]   wval_q, wval_d;
  logic                timeout_q, timeout_d;
  logic                tie_q, tie_d;
  logic [FRAC_W:0]     eps_cur;

`ifdef MAXNET_PROGEPS_EN
  logic [FRAC_W:0]     eps_q, eps_d;
  assign eps_cur = eps_q;
`else
  assign eps_cur = EPS_C;
`endif

  // Datapath: sum, per-channel inhibition and clamped update, all from the a_q snapshot.
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    diff  [N];
  logic [PROD_W-1:0]   prod  [N];
  logic [SUM_W:0]      inh   [N];
  logic [DATA_W-1:0]   a_upd [N];
  logic [N-1:0]        nz, in_nz;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    low_nz, low_prev;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + SUM_W'(a_q[i]);
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      diff[i]  = sum - SUM_W'(a_q[i]);
      prod[i]  = PROD_W'(eps_cur) * PROD_W'(diff[i]);
      inh[i]   = prod[i][PROD_W-1:FRAC_W];
      a_upd[i] = ((SUM_W + 1)'(a_q[i]) > inh[i]) ? a_q[i] - inh[i][DATA_W-1:0] : '0;
      nz[i]    = |a_q[i];
      in_nz[i] = |bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  // Population count and lowest-index priority picks (scan downward so lowest wins).
  always_comb begin
    cnt      = '0;
    low_nz   = '0;
    low_prev = '0;
    for (int i = 0; i < N; i++) cnt = cnt + CNT_W'(nz[i]);
    for (int i = N - 1; i >= 0; i--) begin
      if (nz[i])         low_nz   = IDX_W'(i);
      if (prevmask_q[i]) low_prev = IDX_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    prevmask_d = prevmask_q;
    iter_d     = iter_q;
    widx_d     = widx_q;
    wval_d     = wval_q;
    timeout_d  = timeout_q;
    tie_d      = tie_q;
`ifdef MAXNET_PROGEPS_EN
    eps_d      = eps_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          for (int i = 0; i < N; i++) a_d[i] = bus.in_data[i*DATA_W +: DATA_W];
          prevmask_d = in_nz;
          iter_d     = '0;
          widx_d     = '0;
          wval_d     = '0;
          timeout_d  = 1'b0;
          tie_d      = 1'b0;
`ifdef MAXNET_PROGEPS_EN
          eps_d      = bus.eps_in;
`endif
          state_d    = StCheck;
        end
      end
      StCheck: begin
        if (cnt == CNT_W'(1)) begin
          widx_d  = low_nz;
          wval_d  = a_q[low_nz];
          state_d = StDone;
        end else if (cnt == '0) begin
          // Everyone died in the last update: credit the lowest survivor before it.
          tie_d   = 1'b1;
          widx_d  = low_prev;
          wval_d  = '0;
          state_d = StDone;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          timeout_d = 1'b1;
          widx_d    = low_nz;
          wval_d    = a_q[low_nz];
          state_d   = StDone;
        end else begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        a_d        = a_upd;
        prevmask_d = nz;
        iter_d     = iter_q + ITER_W'(1);
        state_d    = StCheck;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      a_q        <= '{default: '0};
      prevmask_q <= '0;
      iter_q     <= '0;
      widx_q     <= '0;
      wval_q     <= '0;
      timeout_q  <= 1'b0;
      tie_q      <= 1'b0;
`ifdef MAXNET_PROGEPS_EN
      eps_q      <= EPS_C;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      prevmask_q <= prevmask_d;
      iter_q     <= iter_d;
      widx_q     <= widx_d;
      wval_q     <= wval_d;
      timeout_q  <= timeout_d;
      tie_q      <= tie_d;
`ifdef MAXNET_PROGEPS_EN
      eps_q      <= eps_d;
`endif
    end
  end

  assign bus.ready      = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.winner_idx = widx_q;
  assign bus.winner_val = wval_q;
  assign bus.iter_count = iter_q;
  assign bus.timeout    = timeout_q;
  assign bus.tie        = tie_q;
endmodule

// File: tb/tb_maxnet_core.sv
module tb_maxnet_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  maxnet_core_if #(.N(4), .DATA_W(8), .FRAC_W(8), .ITER_W(5)) if0 ();
  maxnet_core_if #(.N(4), .DATA_W(8), .FRAC_W(8), .ITER_W(5)) if1 ();

  maxnet_core #(.N(4), .DATA_W(8), .FRAC_W(8), .EPS(32), .MAX_ITER(16), .ITER_W(5)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  maxnet_core #(.N(4), .DATA_W(8), .FRAC_W(8), .EPS(256), .MAX_ITER(16), .ITER_W(5)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // Observation mux so one task can drive and watch either instance.
  logic       sel = 1'b0;
  logic       m_ready, m_busy, m_done, m_to, m_tie;
  logic [1:0] m_idx;
  logic [7:0] m_val;
  logic [4:0] m_iter;

  always_comb begin
    m_ready = sel ? if1.ready      : if0.ready;
    m_busy  = sel ? if1.busy       : if0.busy;
    m_done  = sel ? if1.done       : if0.done;
    m_idx   = sel ? if1.winner_idx : if0.winner_idx;
    m_val   = sel ? if1.winner_val : if0.winner_val;
    m_iter  = sel ? if1.iter_count : if0.iter_count;
    m_to    = sel ? if1.timeout    : if0.timeout;
    m_tie   = sel ? if1.tie        : if0.tie;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start one run on the selected instance and check latency and results.
  // noisy: keep toggling start and scrambling in_data while busy.
  task automatic run(input logic s, input logic [31:0] data, input int exp_lat,
                     input int exp_idx, input int exp_val, input int exp_iter,
                     input int exp_to, input int exp_tie, input string tag,
                     input logic noisy);
    int lat;
    sel = s;
    @(negedge clk);
    if (s) begin if1.start = 1'b1; if1.in_data = data; end
    else   begin if0.start = 1'b1; if0.in_data = data; end
    @(posedge clk); #1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    lat = 1;
    check({tag, " busy after start"}, {31'b0, m_busy}, 1);
    check({tag, " ready after start"}, {31'b0, m_ready}, 0);
    while (!m_done && lat < 200) begin
      if (noisy) begin
        if0.start   = lat[0];
        if0.in_data = $urandom;
      end
      @(posedge clk); #1;
      lat++;
    end
    if0.start = 1'b0;
    check({tag, " done"}, {31'b0, m_done}, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " winner_idx"}, {30'b0, m_idx}, exp_idx);
    check({tag, " winner_val"}, {24'b0, m_val}, exp_val);
    check({tag, " iter_count"}, {27'b0, m_iter}, exp_iter);
    check({tag, " timeout"}, {31'b0, m_to}, exp_to);
    check({tag, " tie"}, {31'b0, m_tie}, exp_tie);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, {31'b0, m_done}, 0);
    check({tag, " ready after done"}, {31'b0, m_ready}, 1);
    check({tag, " winner_val held"}, {24'b0, m_val}, exp_val);
  endtask

  initial begin
    if0.start = 1'b0; if0.in_data = '0;
    if1.start = 1'b0; if1.in_data = '0;
`ifdef MAXNET_PROGEPS_EN
    if0.eps_in = 9'd32;
    if1.eps_in = 9'd256;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {31'b0, if0.ready}, 1);
    check("reset busy", {31'b0, if0.busy}, 0);
    check("reset done", {31'b0, if0.done}, 0);
    check("reset idx", {30'b0, if0.winner_idx}, 0);
    check("reset val", {24'b0, if0.winner_val}, 0);
    check("reset iter", {27'b0, if0.iter_count}, 0);
    check("reset timeout", {31'b0, if0.timeout}, 0);
    check("reset tie", {31'b0, if0.tie}, 0);
    @(negedge clk);
    rst = 1'b1;

    // ch3..ch0 packed high to low
    run(1'b0, {8'd40, 8'd30, 8'd20, 8'd10}, 18, 3, 25, 8, 0, 0, "s1", 1'b0);
    run(1'b0, {8'd0, 8'd77, 8'd0, 8'd0}, 2, 2, 77, 0, 0, 0, "single", 1'b0);
    run(1'b0, {8'd0, 8'd0, 8'd50, 8'd50}, 34, 0, 9, 16, 1, 0, "pair", 1'b0);
    run(1'b1, {8'd0, 8'd0, 8'd5, 8'd5}, 4, 0, 0, 1, 0, 1, "tie01", 1'b0);
    run(1'b1, {8'd7, 8'd7, 8'd0, 8'd0}, 4, 2, 0, 1, 0, 1, "tie23", 1'b0);
    run(1'b0, 32'd0, 2, 0, 0, 0, 0, 1, "zero", 1'b0);

    // Mid-run reset during the third iteration of the s1 vector.
    sel = 1'b0;
    @(negedge clk);
    if0.start = 1'b1;
    if0.in_data = {8'd40, 8'd30, 8'd20, 8'd10};
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun iter", {27'b0, if0.iter_count}, 2);
    check("midrun busy", {31'b0, if0.busy}, 1);
    check("dut1 tie held", {31'b0, if1.tie}, 1);
    #2 rst = 1'b0;
    #1;
    check("async rst ready", {31'b0, if0.ready}, 1);
    check("async rst busy", {31'b0, if0.busy}, 0);
    check("async rst iter", {27'b0, if0.iter_count}, 0);
    check("async rst dut1 tie", {31'b0, if1.tie}, 0);
    check("async rst dut1 idx", {30'b0, if1.winner_idx}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no done in reset", {31'b0, if0.done}, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("no done after reset", {31'b0, if0.done}, 0);
    end

    run(1'b0, {8'd40, 8'd30, 8'd20, 8'd10}, 18, 3, 25, 8, 0, 0, "restart", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
